// File: rtl/uart_hex_word_rx.sv
// ASCII hex line receiver: assembles hex digits into a DATA_W-bit word, emits it on CR/LF.
// Optional byte echo is built when UART_HEX_WORD_RX_ECHO_EN is defined.
module uart_hex_word_rx #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_48mhz,
  input  logic              reset_n,
  input  logic [7:0]        uart_out_data,
  input  logic              uart_out_valid,
  output logic              uart_out_ready,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_err,
  output logic [7:0]        echo_data,
  output logic              echo_valid,
  input  logic              echo_ready
);

  localparam int unsigned MAX_DIGITS = DATA_W / 4;
  localparam int unsigned CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {COLLECT, DISCARD, EMIT} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] acc, acc_n, word_q, word_n;
  logic [CNT_W-1:0]  digits, digits_n;
  logic              ready_q, ready_n, err_q, err_n;
  logic              accept, is_hex, is_space, is_term;
  logic [3:0]        nibble;
  logic              echo_pend_n;

  assign accept = uart_out_valid && ready_q;

  always_comb begin
    is_hex   = 1'b0;
    nibble   = '0;
    is_space = (uart_out_data == 8'h20);
    is_term  = (uart_out_data == 8'h0D) || (uart_out_data == 8'h0A);
    if (uart_out_data >= 8'h30 && uart_out_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(uart_out_data - 8'h30);
    end else if (uart_out_data >= 8'h61 && uart_out_data <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(uart_out_data - 8'h57);
    end else if (uart_out_data >= 8'h41 && uart_out_data <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(uart_out_data - 8'h37);
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= COLLECT;
      acc     <= '0;
      digits  <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      digits  <= digits_n;
      word_q  <= word_n;
      ready_q <= ready_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    digits_n = digits;
    word_n   = word_q;
    err_n    = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (is_hex) begin
            if (digits == MAX_CNT) begin
              err_n   = 1'b1;
              state_n = DISCARD;
            end else begin
              acc_n    = (acc << 4) | DATA_W'(nibble);
              digits_n = digits + 1'b1;
            end
          end else if (is_term) begin
            if (digits != '0) begin
              word_n  = acc;
              state_n = EMIT;
            end
          end else if (!is_space) begin
            err_n   = 1'b1;
            state_n = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept && is_term) begin
          acc_n    = '0;
          digits_n = '0;
          state_n  = COLLECT;
        end
      end
      EMIT: begin
        if (word_ready) begin
          acc_n    = '0;
          digits_n = '0;
          state_n  = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
    // Ready is registered, so it is derived from the next-cycle state and echo occupancy.
    ready_n = (state_n != EMIT) && !echo_pend_n;
  end

  always_comb begin
    uart_out_ready = ready_q;
    word_data      = word_q;
    word_valid     = (state == EMIT);
    word_err       = err_q;
  end

`ifdef UART_HEX_WORD_RX_ECHO_EN
  logic       echo_pend;
  logic [7:0] echo_q, echo_q_n;

  always_comb begin
    echo_pend_n = echo_pend;
    echo_q_n    = echo_q;
    if (accept) begin
      echo_pend_n = 1'b1;
      echo_q_n    = uart_out_data;
    end else if (echo_pend && echo_ready) begin
      echo_pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      echo_pend <= 1'b0;
      echo_q    <= '0;
    end else begin
      echo_pend <= echo_pend_n;
      echo_q    <= echo_q_n;
    end
  end

  assign echo_valid = echo_pend;
  assign echo_data  = echo_q;
`else
  logic echo_ready_unused;
  assign echo_ready_unused = echo_ready;
  assign echo_pend_n       = 1'b0;
  assign echo_valid        = 1'b0;
  assign echo_data         = '0;
`endif

endmodule
